// File: rtl/mem_fill_writer.sv
// mem_fill_writer
// Fills a burst of memory words with an arithmetic sequence
// (start_value, start_value+step, ...) at consecutive addresses.
// After the write pass it can optionally read the same addresses back
// and compare each word against the regenerated sequence.
//
// Ports
//   clock        sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        command strobe, honoured only while idle
//   base_addr    first burst address
//   length       burst word count minus one
//   start_value  data for the first word
//   step         data increment per word
//   verify_en    request the readback-compare pass
//   busy         high while writing, reading or doing the final compare
//   done         one-cycle completion pulse
//   error        sticky mismatch flag for the last burst
//   error_count  saturating mismatch count for the last burst
//   mem_addr     memory address
//   mem_data     memory write data
//   mem_we       memory write enable
//   mem_q        memory read data, one cycle after the address edge
module mem_fill_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] start_value,
    input  logic [DATA_W-1:0] step,
    input  logic              verify_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] error_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] A_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] D_ZERO  = {DATA_W{1'b0}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] sv_q, sv_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic              verify_q, verify_d;
    logic              cmp_q, cmp_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;

    // Next-state, sequence generation and readback compare.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        base_d   = base_q;
        len_d    = len_q;
        sv_d     = sv_q;
        step_d   = step_q;
        verify_d = verify_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        // A read address presented this cycle returns data next cycle;
        // carry its expected value alongside so the compare lines up.
        cmp_d    = (state_q == ST_READ);
        exp_d    = data_q;

        if (cmp_q && (mem_q != exp_q)) begin
            err_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + A_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    sv_d     = start_value;
                    step_d   = step;
                    verify_d = verify_en;
                    err_d    = 1'b0;
                    cnt_d    = A_ZERO;
                    idx_d    = A_ZERO;
                    addr_d   = base_addr;
                    data_d   = start_value;
                    state_d  = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (idx_q == len_q) begin
                    idx_d = A_ZERO;
                    if (verify_q) begin
                        addr_d  = base_q;
                        data_d  = sv_q;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d  = idx_q + A_ONE;
                    addr_d = addr_q + A_ONE;
                    data_d = data_q + step_q;
                end
            end
            ST_READ: begin
                if (idx_q == len_q) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d  = idx_q + A_ONE;
                    addr_d = addr_q + A_ONE;
                    data_d = data_q + step_q;
                end
            end
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the state being entered so
        // they line up with the state they describe.
        busy_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        we_d   = (state_d == ST_WRITE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= A_ZERO;
            addr_q   <= A_ZERO;
            data_q   <= D_ZERO;
            base_q   <= A_ZERO;
            len_q    <= A_ZERO;
            sv_q     <= D_ZERO;
            step_q   <= D_ZERO;
            verify_q <= 1'b0;
            cmp_q    <= 1'b0;
            exp_q    <= D_ZERO;
            err_q    <= 1'b0;
            cnt_q    <= A_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            base_q   <= base_d;
            len_q    <= len_d;
            sv_q     <= sv_d;
            step_q   <= step_d;
            verify_q <= verify_d;
            cmp_q    <= cmp_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign error_count = cnt_q;
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;
    assign mem_we      = we_q;

endmodule

// File: doc/mem_fill_writer.md
MEM_FILL_WRITER -- requirements
Module: mem_fill_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, command strobe, sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W, first address of the burst.
REQ-007 SHALL have port length, input, ADDR_W, burst word count minus one (1..2^ADDR_W words).
REQ-008 SHALL have port start_value, input, DATA_W, data written at base_addr.
REQ-009 SHALL have port step, input, DATA_W, data increment per word.
REQ-010 SHALL have port verify_en, input, 1, enables the readback-compare pass.
REQ-011 SHALL have port busy, output, 1, high in WRITE, READ and CHECK.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port error, output, 1, sticky mismatch flag.
REQ-014 SHALL have port error_count, output, ADDR_W, saturating mismatch count.
REQ-015 SHALL have port mem_addr, output, ADDR_W, memory port address.
REQ-016 SHALL have port mem_data, output, DATA_W, memory port write data.
REQ-017 SHALL have port mem_we, output, 1, memory port write enable.
REQ-018 SHALL have port mem_q, input, DATA_W, memory read data, valid one cycle after its address was presented at a rising edge.

Function
REQ-019 SHALL implement states IDLE, WRITE, READ, CHECK, DONE; all outputs registered.
REQ-020 In IDLE with start=1 at an edge, SHALL latch base_addr, length, start_value, step, verify_en, clear error and error_count, and enter WRITE.
REQ-021 SHALL ignore start in every state other than IDLE; latched command values SHALL not change mid-burst.
REQ-022 In WRITE, SHALL drive mem_we=1 with one word per cycle for exactly length+1 cycles: mem_addr = base_addr+i mod 2^ADDR_W, mem_data = start_value+i*step mod 2^DATA_W.
REQ-023 Address SHALL wrap 2^ADDR_W-1 -> 0; data SHALL wrap modulo 2^DATA_W; no flag for either wrap.
REQ-024 After the last write cycle, SHALL enter READ if verify_en latched 1, else DONE.
REQ-025 In READ, SHALL drive mem_we=0 and re-issue the same address sequence, one per cycle, for length+1 cycles, regenerating the expected data in step.
REQ-026 SHALL compare mem_q against the expected value of the address issued one cycle earlier; CHECK is one cycle after the last READ address, performing the final compare, then DONE.
REQ-027 On each mismatch, SHALL set error and increment error_count, saturating at 2^ADDR_W-1.
REQ-028 In DONE, SHALL assert done for exactly one cycle with busy=0, mem_we=0, then return to IDLE.
REQ-029 mem_we SHALL be 0 in every state except WRITE.
REQ-030 error and error_count SHALL hold their values from DONE until the next accepted start.
REQ-031 Latency: start sampled at edge k -> first write during cycle k+1; write-only done during cycle k+L+2, where L = length; with verify, done during cycle k+2L+4.

Reset
REQ-032 reset_n low SHALL immediately force state IDLE, busy=0, done=0, error=0, error_count=0, mem_we=0, mem_addr=0, mem_data=0, regardless of clock.
REQ-033 Reset mid-burst SHALL abort the burst with no done pulse; the next start after reset_n rises SHALL run normally.

Verification
REQ-034 base=0, length=2, start_value=1, step=1, verify_en=0 -> writes 1,2,3 to addresses 0,1,2 in three consecutive cycles; done one cycle later; error=0.
REQ-035 base=1022, length=3, start_value=0xFFFE, step=1 -> addresses 1022,1023,0,1 receive 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-036 verify_en=1 against a correct synchronous memory model -> error=0, error_count=0; with the model corrupting address 2 on readback -> error=1, error_count=1.
REQ-037 start pulsed during WRITE -> ignored; burst and done timing unchanged; no second burst.
REQ-038 reset_n low during WRITE word 5 of 10 -> mem_we=0 and busy=0 immediately; no done; a following start completes a correct burst.
REQ-039 length=1023, verify_en=1, step=0 -> 1024 writes, 1024 reads plus CHECK; done during cycle k+2050; error_count=0.
